ascii_time_setter: RTL

//   ASCII-to-BCD time decoder. This is the input-side counterpart of the clock

---
 rtl/ascii_time_setter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ascii_time_setter.sv
// ascii_time_setter: decodes "HH:MM:SS<TERM>" bytes into six BCD digits.
// Ports: char_* byte in, set_* load out (valid/ready), err_pulse/err_code, busy.
module ascii_time_setter #(
  parameter logic [7:0]  TERM_CHAR      = 8'h0D,
  parameter logic [7:0]  SEP_CHAR       = 8'h3A,
  parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       set_valid,
  input  logic       set_ready,
  output logic [3:0] set_hour10,
  output logic [3:0] set_hour1,
  output logic [3:0] set_min10,
  output logic [3:0] set_min1,
  output logic [3:0] set_sec10,
  output logic [3:0] set_sec1,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, H1, C1, M10, M1, C2, S10, S1, TERM, HOLD, DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          char_ready_q, set_valid_q, err_pulse_q, busy_q;
  logic [1:0]    err_code_q;
  logic [3:0]    h10_q, h1_q, m10_q, m1_q, s10_q, s1_q;
  logic [3:0]    o_h10_q, o_h1_q, o_m10_q, o_m1_q, o_s10_q, o_s1_q;

  logic       acc, is_dig, want_dig, want_sep, want_term;
  logic       bad, rng, err_now, counting, tmo;
  logic [7:0] dsub;
  logic [3:0] dv, lim;

  always_comb begin
    acc       = char_valid && char_ready_q;
    is_dig    = (char_data >= 8'h30) && (char_data <= 8'h39);
    dsub      = char_data - 8'h30;
    dv        = dsub[3:0];
    want_dig  = 1'b0;
    want_sep  = 1'b0;
    want_term = 1'b0;
    lim       = 4'd9;
    unique case (state_q)
      IDLE:     begin want_dig = 1'b1; lim = 4'd2; end
      H1: begin
        want_dig = 1'b1;
        lim      = (h10_q == 4'd2) ? 4'd3 : 4'd9;
      end
      M10, S10: begin want_dig = 1'b1; lim = 4'd5; end
      M1, S1:   want_dig = 1'b1;
      C1, C2:   want_sep = 1'b1;
      TERM:     want_term = 1'b1;
      default:  ;
    endcase
    bad = (want_dig && !is_dig)
       || (want_sep && (char_data != SEP_CHAR))
       || (want_term && (char_data != TERM_CHAR));
    rng = want_dig && is_dig && (dv > lim);
    // A terminator in IDLE is ignored rather than flagged.
    err_now = acc && (bad || rng)
           && ((state_q inside {H1, C1, M10, M1, C2, S10, S1, TERM})
            || (state_q == IDLE && char_data != TERM_CHAR));
    counting = !(state_q inside {IDLE, HOLD});
    // An accepted byte in the expiry cycle wins over the timeout.
    tmo = counting && !acc && (cnt_q == LAST);

    state_d = state_q;
    unique case (state_q)
      IDLE:  if (acc && char_data != TERM_CHAR) state_d = H1;
      H1:    if (acc) state_d = C1;
      C1:    if (acc) state_d = M10;
      M10:   if (acc) state_d = M1;
      M1:    if (acc) state_d = C2;
      C2:    if (acc) state_d = S10;
      S10:   if (acc) state_d = S1;
      S1:    if (acc) state_d = TERM;
      TERM:  if (acc) state_d = HOLD;
      HOLD:  if (set_valid_q && set_ready) state_d = IDLE;
      DRAIN: if (acc && char_data == TERM_CHAR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A stray terminator both raises the error and ends the drain.
    if (err_now)
      state_d = (char_data == TERM_CHAR) ? IDLE : DRAIN;
    if (tmo)
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      char_ready_q <= 1'b1;
      set_valid_q  <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= 2'b00;
      busy_q       <= 1'b0;
      h10_q <= '0; h1_q <= '0; m10_q <= '0;
      m1_q  <= '0; s10_q <= '0; s1_q <= '0;
      o_h10_q <= '0; o_h1_q <= '0; o_m10_q <= '0;
      o_m1_q  <= '0; o_s10_q <= '0; o_s1_q <= '0;
    end else begin
      state_q      <= state_d;
      char_ready_q <= (state_d != HOLD);
      busy_q       <= (state_d != IDLE);
      err_pulse_q  <= err_now || tmo;
      if (tmo)
        err_code_q <= 2'b11;
      else if (err_now)
        err_code_q <= bad ? 2'b01 : 2'b10;
      cnt_q <= (acc || !counting || tmo) ? '0 : cnt_q + 1'b1;
      if (acc && !err_now && state_d != state_q) begin
        unique case (state_q)
          IDLE: h10_q <= dv;
          H1:   h1_q  <= dv;
          M10:  m10_q <= dv;
          M1:   m1_q  <= dv;
          S10:  s10_q <= dv;
          S1:   s1_q  <= dv;
          TERM: begin
            o_h10_q <= h10_q; o_h1_q <= h1_q;
            o_m10_q <= m10_q; o_m1_q <= m1_q;
            o_s10_q <= s10_q; o_s1_q <= s1_q;
            set_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state_q == HOLD && set_valid_q && set_ready)
        set_valid_q <= 1'b0;
    end
  end

  assign char_ready = char_ready_q;
  assign set_valid  = set_valid_q;
  assign set_hour10 = o_h10_q;
  assign set_hour1  = o_h1_q;
  assign set_min10  = o_m10_q;
  assign set_min1   = o_m1_q;
  assign set_sec10  = o_s10_q;
  assign set_sec1   = o_s1_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign busy       = busy_q;

endmodule
